// File: rtl/pll_rst_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies the synchronized lock and
// releases per-domain resets in order, re-arming on lock loss with a bounded retry budget.
module pll_rst_sequencer #(
  parameter int N_DOM        = 4,
  parameter int RST_PULSE    = 32,
  parameter int LOCK_TIMEOUT = 360000,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGE_GAP    = 16,
  parameter int MAX_RETRY    = 7
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             restart,
  output logic             pll_rst,
  output logic [N_DOM-1:0] dom_rst,
  output logic             ready,
  output logic             fault,
  output logic [3:0]       retry_cnt,
  output logic [7:0]       loss_cnt,
  output logic [2:0]       state
);

  localparam int REL_LEN = N_DOM * STAGE_GAP;
  localparam int TERM_A  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int TERM_B  = (LOCK_STABLE > REL_LEN) ? LOCK_STABLE : REL_LEN;
  localparam int TERM    = (TERM_A > TERM_B) ? TERM_A : TERM_B;
  localparam int CW      = $clog2(TERM);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    timer_q, timer_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= S_RESET_PLL;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= locked;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      dom_rst_q <= dom_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign retry_inc = retry_q + 4'd1;

  // Restart outranks lock loss, which outranks timeout and stable completion.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = S_RESET_PLL;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (timer_q == CW'(RST_PULSE - 1)) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
            timer_d = '0;
          end else if (timer_q == CW'(LOCK_TIMEOUT - 1)) begin
            timer_d = '0;
            retry_d = retry_inc;
            state_d = (retry_inc == 4'(MAX_RETRY)) ? S_FAULT : S_RESET_PLL;
          end else begin
            timer_d = timer_q + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == CW'(LOCK_STABLE - 1)) begin
            state_d = S_RELEASE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CW'(1);
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_RESET_PLL;
            timer_d = '0;
            retry_d = '0;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end else if (state_q == S_RELEASE) begin
            if (timer_q == CW'(REL_LEN - 1)) begin
              state_d = S_RUN;
              timer_d = '0;
              retry_d = '0;
            end else begin
              timer_d = timer_q + CW'(1);
            end
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_PLL;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each changes on the edge entering a state.
  always_comb begin
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
    dom_rst_d = '1;
    if (state_d == S_RUN) begin
      dom_rst_d = '0;
    end else if (state_d == S_RELEASE) begin
      for (int k = 0; k < N_DOM; k++) begin
        dom_rst_d[k] = (timer_d < CW'(k * STAGE_GAP));
      end
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst   = dom_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule
